// File: rtl/div_arb_pkg.sv
// div_arb_pkg: op encodings, arbiter FSM states and the result-cache entry shared by div_arbiter.
package div_arb_pkg;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;
  typedef struct packed {
    logic [31:0] divident;
    logic [31:0] divisor;
    logic [1:0]  op;
    logic [31:0] result;
    logic        dbz;
    logic        valid;
  } cache_t;
endpackage

// File: rtl/div_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker; grants the first set request at or after ptr_i, wrapping.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) idx_o = IDX_W'((int'(ptr_i) + k) % N);
  end
  assign any_o = |req_i;
  assign gnt_o = any_o ? N'(1) << idx_o : '0;
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one radix-2 divider among NUM_REQ requesters.
// Define DIV_ARB_RESULT_CACHE_EN to add a one-entry result cache that bypasses the divider on repeats.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [32*NUM_REQ-1:0] req_divident_i,
  input  logic [32*NUM_REQ-1:0] req_divisor_i,
  input  logic [2*NUM_REQ-1:0]  req_op_i,
  output logic [NUM_REQ-1:0]    resp_valid_o,
  output logic [31:0]           resp_result_o,
  output logic                  resp_dbz_o,
  output logic                  div_ce_o,
  output logic [31:0]           div_divident_o,
  output logic [31:0]           div_divisor_o,
  output logic [1:0]            div_op_o,
  output logic                  div_valid_o,
  input  logic [31:0]           div_result_i,
  input  logic                  div_ready_i,
  input  logic                  div_dbz_i
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_RESP  = RESP;
  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, grant_idx_q, grant_idx_d, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;
  logic [31:0]        divident_q, divident_d, divisor_q, divisor_d;
  logic [1:0]         op_q, op_d;
  logic               valid_q, valid_d;
  logic [31:0]        result_q, result_d;
  logic               dbz_q, dbz_d;
  logic [31:0]        sel_divident, sel_divisor, hit_result;
  logic [1:0]         sel_op;
  logic               hit, hit_dbz;
  rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );
  assign sel_divident = req_divident_i[32*pick_idx +: 32];
  assign sel_divisor  = req_divisor_i[32*pick_idx +: 32];
  assign sel_op       = req_op_i[2*pick_idx +: 2];
`ifdef DIV_ARB_RESULT_CACHE_EN
  cache_t cache_q;
  assign hit = cache_q.valid && cache_q.divident == sel_divident &&
               cache_q.divisor == sel_divisor && cache_q.op == sel_op;
  assign hit_result = cache_q.result;
  assign hit_dbz    = cache_q.dbz;
  // RESP always holds the operands and result of the request just served, hit or not.
  always_ff @(posedge clk)
    if (reset) cache_q <= '0;
    else if (state_q == S_RESP)
      cache_q <= '{divident: divident_q, divisor: divisor_q, op: op_q,
                   result: result_q, dbz: dbz_q, valid: 1'b1};
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
  assign hit_dbz    = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    divident_d  = divident_q;
    divisor_d   = divisor_q;
    op_d        = op_q;
    valid_d     = valid_q;
    result_d    = result_q;
    dbz_d       = dbz_q;
    if (state_q == S_IDLE && pick_any) begin
      grant_idx_d = pick_idx;
      divident_d  = sel_divident;
      divisor_d   = sel_divisor;
      op_d        = sel_op;
      state_d     = hit ? S_RESP : S_ISSUE;
      valid_d     = !hit;
      result_d    = hit ? hit_result : result_q;
      dbz_d       = hit ? hit_dbz : dbz_q;
    end
    // valid drops with div_ready so the divider never sees a restart the cycle after done.
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      state_d  = div_ready_i ? S_RESP : S_WAIT;
      valid_d  = !div_ready_i;
      result_d = div_ready_i ? div_result_i : result_q;
      dbz_d    = div_ready_i ? div_dbz_i : dbz_q;
    end
    if (state_q == S_RESP) begin
      state_d  = S_IDLE;
      rr_ptr_d = grant_idx_q == IDX_W'(NUM_REQ - 1) ? '0 : grant_idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      divident_q  <= '0;
      divisor_q   <= '0;
      op_q        <= '0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      divident_q  <= divident_d;
      divisor_q   <= divisor_d;
      op_q        <= op_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      dbz_q       <= dbz_d;
    end
  assign req_ready_o    = (state_q == S_IDLE && !reset) ? pick_gnt : '0;
  assign resp_valid_o   = (state_q == S_RESP && !reset) ? NUM_REQ'(1) << grant_idx_q : '0;
  assign resp_result_o  = result_q;
  assign resp_dbz_o     = dbz_q;
  assign div_ce_o       = 1'b1;
  assign div_divident_o = divident_q;
  assign div_divisor_o  = divisor_q;
  assign div_op_o       = op_q;
  assign div_valid_o    = valid_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter with a behavioural rv32im divider behind it.
module tb_div_arbiter;
  import div_arb_pkg::*;
  localparam int N   = 2;
  localparam int LAT = 32;
  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, resp_valid;
  logic [32*N-1:0] req_divident, req_divisor;
  logic [2*N-1:0]  req_op;
  logic [31:0]     resp_result, div_divident, div_divisor, div_result;
  logic            resp_dbz, div_ce, div_valid, div_ready, div_dbz;
  logic [1:0]      div_op;
  logic            busy, prev_ready;
  int              cnt;
  int              checks = 0, errors = 0;
  int              cyc = 0, rdy_cyc = -1, acc_cyc = -1, starts = 0, bad = 0;
  always #5 clk = ~clk;
  div_arbiter #(.NUM_REQ(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_divident_i (req_divident),
    .req_divisor_i  (req_divisor),
    .req_op_i       (req_op),
    .resp_valid_o   (resp_valid),
    .resp_result_o  (resp_result),
    .resp_dbz_o     (resp_dbz),
    .div_ce_o       (div_ce),
    .div_divident_o (div_divident),
    .div_divisor_o  (div_divisor),
    .div_op_o       (div_op),
    .div_valid_o    (div_valid),
    .div_result_i   (div_result),
    .div_ready_i    (div_ready),
    .div_dbz_i      (div_dbz)
  );
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic signed [31:0] sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (op == OP_DIV)       r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
    else if (op == OP_DIVU) r = (b == 0) ? 32'hFFFF_FFFF : a / b;
    else if (op == OP_REM)  r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
    else                    r = (b == 0) ? a : a % b;
    return {b == 0, r};
  endfunction
  assign {div_dbz, div_result} = ref_div(div_divident, div_divisor, div_op);
  // Divider: starts on div_valid when idle, one-cycle done pulse, samples div_valid again only after that.
  always @(posedge clk)
    if (reset) begin
      busy      <= 1'b0;
      cnt       <= 0;
      div_ready <= 1'b0;
    end else if (div_ready) begin
      div_ready <= 1'b0;
      busy      <= 1'b0;
    end else if (busy) begin
      cnt <= cnt + 1;
      if (cnt == LAT - 1) div_ready <= 1'b1;
    end else if (div_valid) begin
      busy <= 1'b1;
      cnt  <= 0;
    end
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    prev_ready <= div_ready;
    if (div_ready) rdy_cyc <= cyc;
    if (|req_ready) acc_cyc <= cyc;
    if (!reset && !busy && !div_ready && div_valid) starts <= starts + 1;
    if ((|req_ready && div_valid) || $countones(req_ready) > 1 || $countones(resp_valid) > 1 ||
        (prev_ready && div_valid && !reset)) bad <= bad + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic run(input int r, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                     input logic [31:0] er, input logic ed, input bit hit, input string tag);
    int n = 0;
    int s0 = starts;
    req_valid[r] = 1'b1;
    req_divident[32*r +: 32] = a;
    req_divisor[32*r +: 32]  = b;
    req_op[2*r +: 2]         = op;
    #1;
    while (req_ready[r] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check({tag, " accept"}, 32'(req_ready), 32'(1 << r));
    @(negedge clk);
    req_valid[r] = 1'b0;
    n = 0;
    while (resp_valid == '0 && n < 200) begin @(negedge clk); n++; end
    check({tag, " resp_valid"}, 32'(resp_valid), 32'(1 << r));
    check({tag, " result"}, resp_result, er);
    check({tag, " dbz"}, 32'(resp_dbz), 32'(ed));
    check({tag, " latency"}, hit ? 32'(cyc - acc_cyc) : 32'(cyc - rdy_cyc), 32'd1);
    check({tag, " starts"}, 32'(starts - s0), hit ? 32'd0 : 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int n, seen;
    logic [N-1:0] g;
    reset = 1'b1;
    req_valid = '0;
    req_divident = '0;
    req_divisor = '0;
    req_op = '0;
    repeat (3) @(negedge clk);
    req_valid[0] = 1'b1;
    #1;
    check("rst req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_result", resp_result, 32'd0);
    check("rst resp_dbz", 32'(resp_dbz), 32'd0);
    check("rst div_valid", 32'(div_valid), 32'd0);
    check("rst div_ops", div_divident | div_divisor | 32'(div_op), 32'd0);
    check("div_ce", 32'(div_ce), 32'd1);
    run(0, 32'd100, 32'd7, OP_DIV, 32'd14, 1'b0, 1'b0, "div100_7");
    run(1, 32'hFFFF_FFF9, 32'd2, OP_REM, 32'hFFFF_FFFF, 1'b0, 1'b0, "rem-7_2");
    run(0, 32'hFFFF_FFFE, 32'd2, OP_DIVU, 32'h7FFF_FFFF, 1'b0, 1'b0, "divu_big");
    run(0, 32'd5, 32'd0, OP_DIV, 32'hFFFF_FFFF, 1'b1, 1'b0, "div5_0");
    run(1, 32'd5, 32'd0, OP_REMU, 32'd5, 1'b1, 1'b0, "remu5_0");
    // rr_ptr is now 0: both held, grants must alternate starting at 0
    req_divident = {32'd9, 32'd100};
    req_divisor  = {32'd3, 32'd7};
    req_op       = {OP_DIVU, OP_DIV};
    req_valid    = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == '0 && n < 100) begin @(negedge clk); n++; end
      g = req_ready;
      check("cont grant", 32'(g), (k % 2 == 1) ? 32'd2 : 32'd1);
      @(negedge clk);
      n = 0;
      while (resp_valid == '0 && n < 200) begin @(negedge clk); n++; end
      check("cont resp", 32'(resp_valid), 32'(g));
      check("cont result", resp_result, (k % 2 == 1) ? 32'd3 : 32'd14);
    end
    req_valid = '0;
    @(negedge clk);
    run(0, 32'd100, 32'd3, OP_DIVU, 32'd33, 1'b0, 1'b0, "pre_rst");
    req_valid[0] = 1'b1;
    req_divisor[31:0] = 32'd9;
    #1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("rst_mid accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    repeat (10) @(negedge clk);
    check("rst_mid busy", 32'(div_valid), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid div_valid", 32'(div_valid), 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (resp_valid != '0) seen++; end
    check("rst_mid no resp", 32'(seen), 32'd0);
    run(0, 32'd9, 32'd3, OP_DIVU, 32'd3, 1'b0, 1'b0, "divu9_3");
`ifdef DIV_ARB_RESULT_CACHE_EN
    run(0, 32'd100, 32'd7, OP_DIV, 32'd14, 1'b0, 1'b0, "cache miss");
    run(0, 32'd100, 32'd7, OP_DIV, 32'd14, 1'b0, 1'b1, "cache hit");
    run(0, 32'd100, 32'd6, OP_DIV, 32'd16, 1'b0, 1'b0, "cache new");
`endif
    check("protocol", 32'(bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
